mod_2011_rr_scheduler: RTL

//  Shares one combinational 500-bit mod-2011 reducer among NUM_REQ requesters.

---
 rtl/mod_2011_pkg.sv | 17 +
 rtl/x_500_mod_2011.sv | 37 +++
 rtl/mod_2011_rr_scheduler.sv | 112 +++++++++++
 3 files changed

// File: rtl/mod_2011_pkg.sv
// Shared constants and types for the mod-2011 residue datapath.
package mod_2011_pkg;

  localparam int unsigned MODULUS = 2011;
  localparam int          IN_W    = 500;
  localparam int          R_W     = 11;

  // Operands are split into 11-bit digits; 2^11 mod 2011 = 37 folds each digit weight.
  localparam int          DIG_W   = 11;
  localparam int unsigned FOLD_K  = 37;

  // Folds of a 32-bit partial sum needed to bring it below 2*MODULUS.
  localparam int          N_FOLD  = 5;

  typedef logic [R_W-1:0] residue_t;

endpackage

// File: rtl/x_500_mod_2011.sv
// Combinational reduction of a 500-bit operand modulo 2011.
// X = sum d_k * 2048^k, and 2048^k == 37^k (mod 2011), so the digits are
// weighted by constant residues, summed, then folded down to one residue.
module x_500_mod_2011
  import mod_2011_pkg::*;
(
  input  logic [IN_W-1:0] x,
  output residue_t        r
);

  localparam int N_DIG = (IN_W + DIG_W - 1) / DIG_W;

  logic [N_DIG*DIG_W-1:0] x_pad;
  logic [31:0]            acc;
  logic [31:0]            fold;
  residue_t               w;

  // Weighted digit sum, folded at bit 11 until a single conditional subtract finishes it.
  always_comb begin
    // NOTE: blocking assignments here build a chain of combinational stages inside one
    // process; each line reads the value produced by the line before it.
    x_pad            = '0;
    x_pad[IN_W-1:0]  = x;
    acc              = '0;
    w                = residue_t'(1);
    for (int k = 0; k < N_DIG; k++) begin
      acc = acc + 32'(x_pad[k*DIG_W +: DIG_W]) * 32'(w);
      w   = residue_t'((32'(w) * FOLD_K) % MODULUS);
    end
    fold = acc;
    for (int f = 0; f < N_FOLD; f++) begin
      fold = 32'(fold[31:DIG_W]) * FOLD_K + 32'(fold[DIG_W-1:0]);
    end
    r = (fold >= MODULUS) ? residue_t'(fold - MODULUS) : residue_t'(fold);
  end

endmodule

// File: rtl/mod_2011_rr_scheduler.sv
// Round-robin front end sharing one mod-2011 reducer between NUM_REQ requesters.
// Operand register -> reducer -> result register, valid/ready on both sides.
module mod_2011_rr_scheduler
  import mod_2011_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [R_W-1:0]          res_data,
  output logic [ID_W-1:0]         res_id,
  output logic                    busy
);

  typedef struct packed {
    logic            hit;
    logic [ID_W-1:0] idx;
  } grant_t;

  // First valid requester at or after ptr, searching cyclically.
  function automatic grant_t find_first(input logic [NUM_REQ-1:0] vld,
                                        input logic [ID_W-1:0]    ptr);
    grant_t g;
    int     j;
    g = '0;
    // Walk from farthest to nearest so the nearest valid requester wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (vld[j]) begin
        g.hit = 1'b1;
        g.idx = ID_W'(j);
      end
    end
    return g;
  endfunction

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] idx);
    return (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  logic            s1_vld;
  logic            s2_vld;
  logic [IN_W-1:0] s1_op;
  logic [ID_W-1:0] s1_id;
  logic [ID_W-1:0] rr_ptr;
  logic            s1_free;
  logic            s2_free;
  logic            take;
  grant_t          gnt;
  residue_t        red_res;

  // Stage availability and the combinational grant.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    s2_free   = !s2_vld || res_ready;
    s1_free   = !s1_vld || s2_free;
    gnt       = find_first(req_valid, rr_ptr);
    take      = s1_free && gnt.hit;
    req_ready = '0;
    if (rst_n && take) req_ready[gnt.idx] = 1'b1;
  end

  x_500_mod_2011 u_reducer (
    .x (s1_op),
    .r (red_res)
  );

  // Control state and result registers: stage valids, round-robin pointer, s2 payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s2_vld   <= 1'b0;
      rr_ptr   <= '0;
      res_data <= '0;
      res_id   <= '0;
    end else begin
      if (s1_free) begin
        s1_vld <= gnt.hit;
        if (gnt.hit) rr_ptr <= next_ptr(gnt.idx);
      end
      if (s2_free) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          res_data <= red_res;
          res_id   <= s1_id;
        end
      end
    end
  end

  // Stage-1 operand capture on a grant.
  always_ff @(posedge clk) begin
    // NOTE: the 500-bit operand register has no reset; s1_vld qualifies it, so a
    // reset here would only cost flops with reset pins and routing.
    if (take) begin
      s1_op <= req_data[gnt.idx*IN_W +: IN_W];
      s1_id <= gnt.idx;
    end
  end

  assign res_valid = s2_vld;
  assign busy      = s1_vld || s2_vld;

endmodule
